// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard unit and the ID-stage operand muxes:
// forwarding-select encoding and the shadow-pipeline entry layout.
package hazard_unit_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef struct packed {
        logic       we;
        logic [4:0] wr;
        logic       load;
    } shadow_t;

    localparam int SH_W = $bits(shadow_t);

    // True when an in-flight entry writes the register a used source reads.
    // x0 is hard-wired to zero and never counts as a producer.
    function automatic logic entry_match(input shadow_t entry, input logic [4:0] rs,
                                         input logic used);
        return entry.we && (entry.wr == rs) && (rs != 5'd0) && used;
    endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// One stage of the destination-tracking shadow pipeline; a bubble request
// loads an empty entry instead of the incoming one.
module hazard_shadow_stage
    import hazard_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            bubble,
    input  logic [SH_W-1:0] d,
    output logic [SH_W-1:0] q
);

    logic [SH_W-1:0] entry_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_reg <= '0;
        end else if (bubble) begin
            entry_reg <= '0;
        end else begin
            entry_reg <= d;
        end
    end

    assign q = entry_reg;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard detection: tracks in-flight destinations in a private
// shadow pipeline, drives forwarding selects, stall/flush controls and counters.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int FORWARD_EN     = 1,
    parameter int RF_WRITE_FIRST = 1,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [1:0]       ID_rf_re,
    input  logic             ID_rf_we,
    input  logic [4:0]       ID_wR,
    input  logic             ID_is_load,
    input  logic             EX_redirect,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             control_hazard,
    output logic             data_hazard,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic FWD_ON  = (FORWARD_EN != 0);
    localparam logic WB_LIVE = (RF_WRITE_FIRST == 0);

    logic [SH_W-1:0] id_bits;
    logic [SH_W-1:0] sh_ex_bits;
    logic [SH_W-1:0] sh_mem_bits;
    logic [SH_W-1:0] sh_wb_bits;
    shadow_t         id_entry;
    shadow_t         sh_ex;
    shadow_t         sh_mem;
    shadow_t         sh_wb;
    logic            bubble;
    logic            raw_stall;
    logic            unused_load;

    assign id_entry    = '{we: ID_rf_we, wr: ID_wR, load: ID_is_load};
    assign id_bits     = id_entry;
    assign sh_ex       = shadow_t'(sh_ex_bits);
    assign sh_mem      = shadow_t'(sh_mem_bits);
    assign sh_wb       = shadow_t'(sh_wb_bits);
    assign unused_load = sh_mem.load ^ sh_wb.load;

    // Only the EX entry can be squashed; older entries always advance.
    hazard_shadow_stage u_sh_ex (
        .clk    (clk),
        .rst    (rst),
        .bubble (bubble),
        .d      (id_bits),
        .q      (sh_ex_bits)
    );

    hazard_shadow_stage u_sh_mem (
        .clk    (clk),
        .rst    (rst),
        .bubble (1'b0),
        .d      (sh_ex_bits),
        .q      (sh_mem_bits)
    );

    hazard_shadow_stage u_sh_wb (
        .clk    (clk),
        .rst    (rst),
        .bubble (1'b0),
        .d      (sh_mem_bits),
        .q      (sh_wb_bits)
    );

    logic [4:0] src_rs [2];
    logic [1:0] src_sel [2];
    logic [1:0] match_ex;
    logic [1:0] match_mem;
    logic [1:0] match_wb;
    logic [1:0] load_use;
    logic [1:0] wait_retire;

    assign src_rs[0] = ID_rs1;
    assign src_rs[1] = ID_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign match_ex[gi]  = entry_match(sh_ex,  src_rs[gi], ID_rf_re[gi]);
            assign match_mem[gi] = entry_match(sh_mem, src_rs[gi], ID_rf_re[gi]);
            assign match_wb[gi]  = entry_match(sh_wb,  src_rs[gi], ID_rf_re[gi]);

            assign load_use[gi]    = match_ex[gi] & sh_ex.load;
            assign wait_retire[gi] = match_ex[gi] | match_mem[gi] | (match_wb[gi] & WB_LIVE);

            // Youngest producer wins; a write-first regfile already covers WB.
            assign src_sel[gi] = !FWD_ON                 ? FWD_RF  :
                                 match_ex[gi]            ? FWD_EX  :
                                 match_mem[gi]           ? FWD_MEM :
                                 (match_wb[gi] & WB_LIVE) ? FWD_WB  : FWD_RF;
        end
    endgenerate

    assign raw_stall = FWD_ON ? (|load_use) : (|wait_retire);

    // A redirect makes the ID instruction wrong-path, so it overrides any stall
    // and lets the PC take the branch target.
    always_comb begin
        control_hazard = 1'b0;
        if_id_flush    = 1'b0;
        data_hazard    = 1'b0;
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        if (EX_redirect) begin
            control_hazard = 1'b1;
            if_id_flush    = 1'b1;
        end else if (raw_stall) begin
            data_hazard = 1'b1;
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
        end
    end

    assign bubble   = control_hazard | data_hazard;
    assign fwd_sel1 = src_sel[0];
    assign fwd_sel2 = src_sel[1];

    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;
    logic [CNT_W-1:0] flush_cnt_next;

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        if (data_hazard && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
        if (control_hazard && (flush_cnt_reg != {CNT_W{1'b1}})) begin
            flush_cnt_next = flush_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: one forwarding instance and one
// no-forwarding instance share stimulus; each step targets one of them.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] ID_rs1 = '0;
    logic [4:0] ID_rs2 = '0;
    logic [1:0] ID_rf_re = '0;
    logic       ID_rf_we = 1'b0;
    logic [4:0] ID_wR = '0;
    logic       ID_is_load = 1'b0;
    logic       EX_redirect = 1'b0;

    logic        pc_stall_a, if_id_stall_a, if_id_flush_a, control_hazard_a, data_hazard_a;
    logic [1:0]  fwd_sel1_a, fwd_sel2_a;
    logic [31:0] stall_cnt_a, flush_cnt_a;
    logic        pc_stall_b, if_id_stall_b, if_id_flush_b, control_hazard_b, data_hazard_b;
    logic [1:0]  fwd_sel1_b, fwd_sel2_b;
    logic [31:0] stall_cnt_b, flush_cnt_b;

    always #5 clk = ~clk;

    hazard_unit #(.FORWARD_EN(1), .RF_WRITE_FIRST(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rf_re(ID_rf_re),
        .ID_rf_we(ID_rf_we), .ID_wR(ID_wR), .ID_is_load(ID_is_load), .EX_redirect(EX_redirect),
        .pc_stall(pc_stall_a), .if_id_stall(if_id_stall_a), .if_id_flush(if_id_flush_a),
        .control_hazard(control_hazard_a), .data_hazard(data_hazard_a),
        .fwd_sel1(fwd_sel1_a), .fwd_sel2(fwd_sel2_a),
        .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    hazard_unit #(.FORWARD_EN(0), .RF_WRITE_FIRST(1), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rf_re(ID_rf_re),
        .ID_rf_we(ID_rf_we), .ID_wR(ID_wR), .ID_is_load(ID_is_load), .EX_redirect(EX_redirect),
        .pc_stall(pc_stall_b), .if_id_stall(if_id_stall_b), .if_id_flush(if_id_flush_b),
        .control_hazard(control_hazard_b), .data_hazard(data_hazard_b),
        .fwd_sel1(fwd_sel1_b), .fwd_sel2(fwd_sel2_b),
        .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    // outs = {pc_stall, if_id_stall, if_id_flush, control_hazard, data_hazard, fwd_sel1, fwd_sel2}
    typedef struct {
        string       tag;
        bit          sel;
        logic [8:0]  outs;
        logic [31:0] sc;
        logic [31:0] fc;
    } rec_t;

    rec_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_sc [2];
    logic [31:0] model_fc [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            model_sc[i] = '0;
            model_fc[i] = '0;
        end
    endtask

    // Drive one ID-stage cycle, record expectations, compare mid-cycle, advance.
    task automatic step(input string tag, input bit sel, input logic r,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] re,
                        input logic we, input logic [4:0] wr, input logic ld, input logic redir,
                        input logic stall, input logic [1:0] f1, input logic [1:0] f2);
        rec_t       rec;
        logic [8:0] got;
        logic [31:0] got_sc;
        logic [31:0] got_fc;
        rst = r; ID_rs1 = rs1; ID_rs2 = rs2; ID_rf_re = re;
        ID_rf_we = we; ID_wR = wr; ID_is_load = ld; EX_redirect = redir;
        rec.tag  = tag;
        rec.sel  = sel;
        rec.outs = {stall, stall, redir, redir, stall, f1, f2};
        rec.sc   = model_sc[sel];
        rec.fc   = model_fc[sel];
        sb.push_back(rec);
        if (r) begin
            model_clear();
        end else begin
            if (stall) model_sc[sel] = model_sc[sel] + 1;
            if (redir) model_fc[sel] = model_fc[sel] + 1;
        end
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({tag, "/scoreboard_empty"}, 64'd0, 64'd1);
        end else begin
            rec = sb.pop_front();
            if (rec.sel) begin
                got    = {pc_stall_b, if_id_stall_b, if_id_flush_b, control_hazard_b,
                          data_hazard_b, fwd_sel1_b, fwd_sel2_b};
                got_sc = stall_cnt_b;
                got_fc = flush_cnt_b;
            end else begin
                got    = {pc_stall_a, if_id_stall_a, if_id_flush_a, control_hazard_a,
                          data_hazard_a, fwd_sel1_a, fwd_sel2_a};
                got_sc = stall_cnt_a;
                got_fc = flush_cnt_a;
            end
            chk({rec.tag, "/outs"}, 64'(got), 64'(rec.outs));
            chk({rec.tag, "/stall_cnt"}, 64'(got_sc), 64'(rec.sc));
            chk({rec.tag, "/flush_cnt"}, 64'(got_fc), 64'(rec.fc));
            $display("txn %-12s dut=%s outs=%b stall_cnt=%0d flush_cnt=%0d",
                     rec.tag, rec.sel ? "b" : "a", got, got_sc, got_fc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ID_rs1 = '0; ID_rs2 = '0; ID_rf_re = '0;
        ID_rf_we = 1'b0; ID_wR = '0; ID_is_load = 1'b0; EX_redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        //   tag           sel rst rs1    rs2    re     we   wr     ld   redir stall f1     f2
        step("rst_a",      0, 0, 5'd0,  5'd0, 2'b00, 0, 5'd0,  0, 0, 0, 2'b00, 2'b00);
        step("rst_b",      1, 0, 5'd0,  5'd0, 2'b00, 0, 5'd0,  0, 0, 0, 2'b00, 2'b00);
        // ALU-to-ALU forwarding from EX
        step("fwd_prod",   0, 0, 5'd0,  5'd0, 2'b00, 1, 5'd5,  0, 0, 0, 2'b00, 2'b00);
        step("fwd_cons",   0, 0, 5'd5,  5'd5, 2'b11, 1, 5'd6,  0, 0, 0, 2'b01, 2'b01);
        // Load-use: one stall cycle, then forward from MEM
        step("lu_load",    0, 0, 5'd1,  5'd0, 2'b01, 1, 5'd7,  1, 0, 0, 2'b00, 2'b00);
        step("lu_stall",   0, 0, 5'd7,  5'd1, 2'b01, 1, 5'd8,  0, 0, 1, 2'b01, 2'b00);
        step("lu_after",   0, 0, 5'd7,  5'd1, 2'b01, 1, 5'd8,  0, 0, 0, 2'b10, 2'b00);
        // x0 destination never matches
        step("x0_load",    0, 0, 5'd1,  5'd0, 2'b01, 1, 5'd0,  1, 0, 0, 2'b00, 2'b00);
        step("x0_use",     0, 0, 5'd0,  5'd0, 2'b11, 0, 5'd0,  0, 0, 0, 2'b00, 2'b00);
        // Branch flush squashes the ID instruction writing x9
        step("br_flush",   0, 0, 5'd0,  5'd0, 2'b00, 1, 5'd9,  0, 1, 0, 2'b00, 2'b00);
        step("br_bubble",  0, 0, 5'd9,  5'd0, 2'b01, 0, 5'd0,  0, 0, 0, 2'b00, 2'b00);
        // Redirect coincides with load-use: flush wins, no stall counted
        step("rd_load",    0, 0, 5'd1,  5'd0, 2'b01, 1, 5'd10, 1, 0, 0, 2'b00, 2'b00);
        step("rd_lu",      0, 0, 5'd10, 5'd0, 2'b01, 1, 5'd11, 0, 1, 0, 2'b01, 2'b00);
        step("rd_after",   0, 0, 5'd0,  5'd0, 2'b00, 0, 5'd0,  0, 0, 0, 2'b00, 2'b00);

        do_reset();
        // No forwarding, write-first regfile: consumer of x5 waits two cycles
        step("nf_prod",    1, 0, 5'd0,  5'd0, 2'b00, 1, 5'd5,  0, 0, 0, 2'b00, 2'b00);
        step("nf_stall1",  1, 0, 5'd5,  5'd0, 2'b01, 1, 5'd6,  0, 0, 1, 2'b00, 2'b00);
        step("nf_stall2",  1, 0, 5'd5,  5'd0, 2'b01, 1, 5'd6,  0, 0, 1, 2'b00, 2'b00);
        step("nf_go",      1, 0, 5'd5,  5'd0, 2'b01, 1, 5'd6,  0, 0, 0, 2'b00, 2'b00);
        // Reset lands in the middle of a second stall
        step("nf_prod2",   1, 0, 5'd0,  5'd0, 2'b00, 1, 5'd5,  0, 0, 0, 2'b00, 2'b00);
        step("nf_stall3",  1, 0, 5'd5,  5'd0, 2'b01, 1, 5'd6,  0, 0, 1, 2'b00, 2'b00);
        step("nf_rst",     1, 1, 5'd5,  5'd0, 2'b01, 1, 5'd6,  0, 0, 1, 2'b00, 2'b00);
        step("nf_post",    1, 0, 5'd5,  5'd0, 2'b01, 1, 5'd6,  0, 0, 0, 2'b00, 2'b00);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
